// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Peripheral window offsets, TCTRL bit positions and the address-decode select enum.
package dmem_pkg;

  localparam int unsigned MMIO_WORDS = 8;
  localparam int unsigned MMIO_OFF_W = 3;

  localparam logic [MMIO_OFF_W-1:0] OFF_GPIO   = 3'd0;
  localparam logic [MMIO_OFF_W-1:0] OFF_TCOUNT = 3'd1;
  localparam logic [MMIO_OFF_W-1:0] OFF_TCMP   = 3'd2;
  localparam logic [MMIO_OFF_W-1:0] OFF_TCTRL  = 3'd3;
  localparam logic [MMIO_OFF_W-1:0] OFF_TSTAT  = 3'd4;
  localparam logic [MMIO_OFF_W-1:0] OFF_CYCLE  = 3'd5;

  localparam int unsigned TCTRL_W     = 3;
  localparam int unsigned TCTRL_EN    = 0;
  localparam int unsigned TCTRL_ACLR  = 1;
  localparam int unsigned TCTRL_IRQEN = 2;

  typedef enum logic {
    SEL_RAM  = 1'b0,
    SEL_MMIO = 1'b1
  } dmem_sel_e;

endpackage

// File: rtl/dmem_timer.sv
// Compare timer: TCOUNT/TCMP/TCTRL/TSTAT registers and the level interrupt.
// Bus writes to TCOUNT beat the count update; a new match beats a same-cycle W1C.
module dmem_timer
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr,
  input  logic [MMIO_OFF_W-1:0] off,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata_c,
  output logic                  irq
);

  logic [DATA_W-1:0]  tcount_q, tcount_n;
  logic [DATA_W-1:0]  tcmp_q, tcmp_n;
  logic [TCTRL_W-1:0] tctrl_q, tctrl_n;
  logic               match_q, match_n;
  logic               irq_q, irq_n;
  logic               hit;

  // Next-state for all timer registers
  always_comb begin
    tcount_n = tcount_q;
    tcmp_n   = tcmp_q;
    tctrl_n  = tctrl_q;
    match_n  = match_q;
    hit      = tctrl_q[TCTRL_EN] && (tcount_q == tcmp_q);

    if (tctrl_q[TCTRL_EN]) begin
      if (hit && tctrl_q[TCTRL_ACLR]) tcount_n = '0;
      else                            tcount_n = tcount_q + DATA_W'(1);
    end

    if (wr) begin
      case (off)
        OFF_TCOUNT: tcount_n = wdata;
        OFF_TCMP:   tcmp_n   = wdata;
        OFF_TCTRL:  tctrl_n  = wdata[TCTRL_W-1:0];
        OFF_TSTAT:  if (wdata[0]) match_n = 1'b0;
        default:    ;
      endcase
    end

    if (hit) match_n = 1'b1;

    // irq is registered from the post-edge MATCH and IRQEN values
    irq_n = match_n && tctrl_n[TCTRL_IRQEN];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tcount_q <= '0;
      tcmp_q   <= '0;
      tctrl_q  <= '0;
      match_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      tcount_q <= tcount_n;
      tcmp_q   <= tcmp_n;
      tctrl_q  <= tctrl_n;
      match_q  <= match_n;
      irq_q    <= irq_n;
    end
  end

  always_comb begin
    rdata_c = '0;
    case (off)
      OFF_TCOUNT: rdata_c = tcount_q;
      OFF_TCMP:   rdata_c = tcmp_q;
      OFF_TCTRL:  rdata_c = DATA_W'(tctrl_q);
      OFF_TSTAT:  rdata_c = DATA_W'(match_q);
      default:    rdata_c = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an 8-word peripheral window (GPIO, CYCLE, timer).
// Define DMEM_TIMER_EN to build the compare timer; otherwise its offsets read 0 and irq is 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MMIO_BASE = 32'h3F8,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] ddata_w,
  input  logic              d_w,
  input  logic              d_r,
  output logic [DATA_W-1:0] ddata_r,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  localparam int unsigned RAM_WORDS = MMIO_BASE;

  logic [DATA_W-1:0]     mem [RAM_WORDS];
  dmem_sel_e             sel;
  logic [ADDR_W-1:0]     rel;
  logic                  win_hit;
  logic [MMIO_OFF_W-1:0] off;
  logic                  mmio_wr;
  logic [GPIO_W-1:0]     gpio_q;
  logic [DATA_W-1:0]     cycle_q;
  logic [DATA_W-1:0]     tmr_rdata;

  // Address decode into RAM or the peripheral window
  always_comb begin
    rel     = daddr - ADDR_W'(MMIO_BASE);
    sel     = (daddr < ADDR_W'(MMIO_BASE)) ? SEL_RAM : SEL_MMIO;
    win_hit = (sel == SEL_MMIO) && (rel < ADDR_W'(MMIO_WORDS));
    off     = rel[MMIO_OFF_W-1:0];
    mmio_wr = d_w && win_hit;
  end

  // RAM has no reset; a write coinciding with reset is dropped
  always_ff @(posedge CLK) begin
    if (!RST && d_w && (sel == SEL_RAM)) mem[daddr] <= ddata_w;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gpio_q  <= '0;
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + DATA_W'(1);
      if (mmio_wr && (off == OFF_GPIO)) gpio_q <= ddata_w[GPIO_W-1:0];
    end
  end

`ifdef DMEM_TIMER_EN
  dmem_timer #(
    .DATA_W (DATA_W)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .wr      (mmio_wr),
    .off     (off),
    .wdata   (ddata_w),
    .rdata_c (tmr_rdata),
    .irq     (irq)
  );
`else
  assign tmr_rdata = '0;
  assign irq       = 1'b0;
`endif

  // Zero-latency read mux; idle bus reads 0
  always_comb begin
    ddata_r = '0;
    if (d_r) begin
      if (sel == SEL_RAM) begin
        ddata_r = mem[daddr];
      end else if (win_hit) begin
        case (off)
          OFF_GPIO:   ddata_r = DATA_W'(gpio_q);
          OFF_TCOUNT,
          OFF_TCMP,
          OFF_TCTRL,
          OFF_TSTAT:  ddata_r = tmr_rdata;
          OFF_CYCLE:  ddata_r = cycle_q;
          default:    ddata_r = '0;
        endcase
      end
    end
  end

  assign gpio_out = gpio_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, GPIO, CYCLE, reset and (with DMEM_TIMER_EN) the timer.
module tb_dmem_responder;

  localparam logic [9:0] A_GPIO   = 10'h3F8;
  localparam logic [9:0] A_TCOUNT = 10'h3F9;
  localparam logic [9:0] A_TCMP   = 10'h3FA;
  localparam logic [9:0] A_TCTRL  = 10'h3FB;
  localparam logic [9:0] A_TSTAT  = 10'h3FC;
  localparam logic [9:0] A_CYCLE  = 10'h3FD;

  logic        CLK = 1'b0;
  logic        RST;
  logic [9:0]  daddr;
  logic [31:0] ddata_w;
  logic        d_w;
  logic        d_r;
  logic [31:0] ddata_r;
  logic [7:0]  gpio_out;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int edges = 0;

  dmem_responder dut (
    .CLK      (CLK),
    .RST      (RST),
    .daddr    (daddr),
    .ddata_w  (ddata_w),
    .d_w      (d_w),
    .d_r      (d_r),
    .ddata_r  (ddata_r),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  always #5 CLK = ~CLK;

  // Reference cycle count: edges seen since reset release
  always @(posedge CLK or posedge RST) begin
    if (RST) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    daddr = a; ddata_w = d; d_w = 1'b1; d_r = 1'b0;
    tick();
    d_w = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a);
    daddr = a; d_r = 1'b1; d_w = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; d_w = 1'b0; d_r = 1'b0; daddr = '0; ddata_w = '0;
    #1;
    total++; if (ddata_r !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=%h", ddata_r, 32'h0); end
    total++; if (gpio_out !== 8'h0) begin bad++; $display("FAIL reset_gpio got=%h want=%h", gpio_out, 8'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    tick();
    rd(A_CYCLE);
    total++; if (ddata_r !== 32'h0) begin bad++; $display("FAIL reset_cycle_held got=%h want=%h", ddata_r, 32'h0); end
    d_r = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    tick();
    rd(A_CYCLE);
    total++; if (ddata_r !== 32'h1) begin bad++; $display("FAIL cycle_after_release got=%h want=%h", ddata_r, 32'h1); end
    d_r = 1'b0;
  endtask

  task automatic test_ram();
    wr(10'h010, 32'hDEADBEEF);
    rd(10'h010);
    total++; if (ddata_r !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_read got=%h want=%h", ddata_r, 32'hDEADBEEF); end
    d_r = 1'b0; #1;
    total++; if (ddata_r !== 32'h0) begin bad++; $display("FAIL ram_idle got=%h want=%h", ddata_r, 32'h0); end
    tick();
    wr(10'h3F7, 32'h12345678);
    rd(10'h3F7);
    total++; if (ddata_r !== 32'h12345678) begin bad++; $display("FAIL ram_top_word got=%h want=%h", ddata_r, 32'h12345678); end
    #1; rd(10'h010);
    total++; if (ddata_r !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_keep got=%h want=%h", ddata_r, 32'hDEADBEEF); end
    d_r = 1'b0;
  endtask

  task automatic test_same_cycle();
    wr(10'h020, 32'd5);
    daddr = 10'h020; ddata_w = 32'd9; d_w = 1'b1; d_r = 1'b1;
    #1;
    total++; if (ddata_r !== 32'd5) begin bad++; $display("FAIL rw_old got=%h want=%h", ddata_r, 32'd5); end
    tick();
    d_w = 1'b0;
    rd(10'h020);
    total++; if (ddata_r !== 32'd9) begin bad++; $display("FAIL rw_new got=%h want=%h", ddata_r, 32'd9); end
    d_r = 1'b0;
  endtask

  task automatic test_gpio();
    wr(A_GPIO, 32'hFFFF_FF3C);
    total++; if (gpio_out !== 8'h3C) begin bad++; $display("FAIL gpio_out got=%h want=%h", gpio_out, 8'h3C); end
    rd(A_GPIO);
    total++; if (ddata_r !== 32'h3C) begin bad++; $display("FAIL gpio_read got=%h want=%h", ddata_r, 32'h3C); end
    tick();
    wr(10'h3FE, 32'h55);
    rd(10'h3FE);
    total++; if (ddata_r !== 32'h0) begin bad++; $display("FAIL reserved6 got=%h want=%h", ddata_r, 32'h0); end
    #1; rd(10'h3FF);
    total++; if (ddata_r !== 32'h0) begin bad++; $display("FAIL reserved7 got=%h want=%h", ddata_r, 32'h0); end
    d_r = 1'b0;
  endtask

  task automatic test_cycle();
    rd(A_CYCLE);
    total++; if (ddata_r !== 32'(edges)) begin bad++; $display("FAIL cycle_count got=%h want=%h", ddata_r, 32'(edges)); end
    tick();
    wr(A_CYCLE, 32'h0);
    rd(A_CYCLE);
    total++; if (ddata_r !== 32'(edges)) begin bad++; $display("FAIL cycle_ro got=%h want=%h", ddata_r, 32'(edges)); end
    d_r = 1'b0;
  endtask

`ifdef DMEM_TIMER_EN
  task automatic test_timer_autoclr();
    logic [31:0] exp_cnt [5];
    exp_cnt[0] = 32'd0; exp_cnt[1] = 32'd1; exp_cnt[2] = 32'd2; exp_cnt[3] = 32'd3; exp_cnt[4] = 32'd0;
    wr(A_TCMP, 32'd3);
    wr(A_TCTRL, 32'hFFFF_FFFF);
    rd(A_TCTRL);
    total++; if (ddata_r !== 32'h7) begin bad++; $display("FAIL tctrl_read got=%h want=%h", ddata_r, 32'h7); end
    for (int i = 0; i < 5; i++) begin
      rd(A_TCOUNT);
      total++; if (ddata_r !== exp_cnt[i]) begin bad++; $display("FAIL tcount_seq%0d got=%h want=%h", i, ddata_r, exp_cnt[i]); end
      total++; if (irq !== (i == 4)) begin bad++; $display("FAIL irq_seq%0d got=%b want=%b", i, irq, (i == 4)); end
      if (i < 4) tick();
    end
    rd(A_TSTAT);
    total++; if (ddata_r !== 32'h1) begin bad++; $display("FAIL tstat_match got=%h want=%h", ddata_r, 32'h1); end
    wr(A_TSTAT, 32'h1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c got=%b want=0", irq); end
    rd(A_TSTAT);
    total++; if (ddata_r !== 32'h0) begin bad++; $display("FAIL tstat_w1c got=%h want=%h", ddata_r, 32'h0); end
    d_r = 1'b0;
  endtask

  task automatic test_priority();
    wr(A_TCTRL, 32'h0);
    wr(A_TSTAT, 32'h1);
    wr(A_TCOUNT, 32'd2);
    wr(A_TCTRL, 32'h7);
    tick();
    rd(A_TCOUNT);
    total++; if (ddata_r !== 32'd3) begin bad++; $display("FAIL prio_pre_count got=%h want=%h", ddata_r, 32'd3); end
    rd(A_TSTAT);
    total++; if (ddata_r !== 32'h0) begin bad++; $display("FAIL prio_pre_stat got=%h want=%h", ddata_r, 32'h0); end
    wr(A_TSTAT, 32'h1);
    rd(A_TSTAT);
    total++; if (ddata_r !== 32'h1) begin bad++; $display("FAIL set_beats_w1c got=%h want=%h", ddata_r, 32'h1); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL set_beats_w1c_irq got=%b want=1", irq); end
    #1; rd(A_TCOUNT);
    total++; if (ddata_r !== 32'd0) begin bad++; $display("FAIL prio_autoclr got=%h want=%h", ddata_r, 32'd0); end
    wr(A_TCOUNT, 32'd100);
    rd(A_TCOUNT);
    total++; if (ddata_r !== 32'd100) begin bad++; $display("FAIL tcount_wr_wins got=%h want=%h", ddata_r, 32'd100); end
    tick();
    rd(A_TCOUNT);
    total++; if (ddata_r !== 32'd101) begin bad++; $display("FAIL tcount_resume got=%h want=%h", ddata_r, 32'd101); end
    d_r = 1'b0;
  endtask
`else
  task automatic test_no_timer();
    wr(A_TCMP, 32'd5);
    rd(A_TCMP);
    total++; if (ddata_r !== 32'h0) begin bad++; $display("FAIL notimer_tcmp got=%h want=%h", ddata_r, 32'h0); end
    tick();
    wr(A_TCTRL, 32'h7);
    wr(A_TCOUNT, 32'd0);
    rd(A_TCTRL);
    total++; if (ddata_r !== 32'h0) begin bad++; $display("FAIL notimer_tctrl got=%h want=%h", ddata_r, 32'h0); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL notimer_irq%0d got=%b want=0", i, irq); end
    end
    wr(A_GPIO, 32'h3C);
    rd(A_GPIO);
    total++; if (ddata_r !== 32'h3C) begin bad++; $display("FAIL notimer_gpio got=%h want=%h", ddata_r, 32'h3C); end
    d_r = 1'b0;
  endtask
`endif

  task automatic test_async_reset();
    logic irq_exp;
`ifdef DMEM_TIMER_EN
    irq_exp = 1'b1;
`else
    irq_exp = 1'b0;
`endif
    wr(A_GPIO, 32'hA5);
    total++; if (gpio_out !== 8'hA5) begin bad++; $display("FAIL pre_rst_gpio got=%h want=%h", gpio_out, 8'hA5); end
    total++; if (irq !== irq_exp) begin bad++; $display("FAIL pre_rst_irq got=%b want=%b", irq, irq_exp); end
    #2;
    RST = 1'b1;
    #1;
    total++; if (gpio_out !== 8'h0) begin bad++; $display("FAIL async_rst_gpio got=%h want=%h", gpio_out, 8'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL async_rst_irq got=%b want=0", irq); end
    rd(A_TCOUNT);
    total++; if (ddata_r !== 32'h0) begin bad++; $display("FAIL async_rst_tcount got=%h want=%h", ddata_r, 32'h0); end
    d_r = 1'b0;
    tick();
    @(negedge CLK);
    RST = 1'b0;
    tick();
    rd(A_CYCLE);
    total++; if (ddata_r !== 32'h1) begin bad++; $display("FAIL rst_release_cycle got=%h want=%h", ddata_r, 32'h1); end
    #1; rd(A_TCTRL);
    total++; if (ddata_r !== 32'h0) begin bad++; $display("FAIL rst_release_tctrl got=%h want=%h", ddata_r, 32'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_release_irq got=%b want=0", irq); end
    d_r = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_same_cycle();
    test_gpio();
    test_cycle();
`ifdef DMEM_TIMER_EN
    test_timer_autoclr();
    test_priority();
`else
    test_no_timer();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
